// File: rtl/uart_pkg.sv
// UART shared definitions: FSM states, framing constants, bit timing.
// Used by both the transmit and receive sides.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int OVERSAMPLE     = 8;
   localparam int CNT_W          = 19;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   typedef enum logic {
      BYTE_HI,
      BYTE_LO
   } byte_sel_t;

   // A prescale of zero runs at the fastest legal rate.
   function automatic logic [CNT_W-1:0] bit_cycles(
      input logic [15:0] p
   );
      logic [CNT_W-1:0] eff;
      eff = (p == 16'd0) ? CNT_W'(1) : CNT_W'(p);
      return eff * CNT_W'(OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 byte framer: start bit, eight data bits LSB first, stop bit.
// A byte offered during the last stop-bit cycle follows with no gap.
module uart_tx_serializer
   import uart_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [15:0] prescale_i,
   input  logic [7:0]  data_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        tx_serial_o,
   output logic        busy_o
);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]          plen_q, plen_d;
   logic [2:0]                idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] sh_q, sh_d;
   logic                      line_q, line_d;
   logic                      done;
   logic                      accept;

   assign done    = (cnt_q == plen_q - CNT_W'(1));
   assign ready_o = (state_q == IDLE) |
                    ((state_q == STOP) & done);
   assign accept  = valid_i & ready_o;
   assign busy_o  = (state_q != IDLE);
   assign tx_serial_o = line_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         plen_q  <= CNT_W'(OVERSAMPLE);
         idx_q   <= '0;
         sh_q    <= '0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         plen_q  <= plen_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      plen_d  = plen_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      line_d  = line_q;
      unique case (state_q)
         IDLE: begin
            cnt_d  = '0;
            line_d = 1'b1;
         end
         START: begin
            if (done) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
               line_d  = sh_q[0];
            end
         end
         DATA: begin
            if (done) begin
               cnt_d = '0;
               if (idx_q == 3'(UART_DATA_BITS - 1)) begin
                  state_d = STOP;
                  line_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + 3'd1;
                  sh_d   = sh_q >> 1;
                  line_d = sh_q[1];
               end
            end
         end
         STOP: begin
            if (done) begin
               state_d = IDLE;
               cnt_d   = '0;
               line_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            line_d  = 1'b1;
         end
      endcase
      // Accept overrides: start bit goes out on the next cycle.
      if (accept) begin
         state_d = START;
         cnt_d   = '0;
         idx_d   = '0;
         sh_d    = data_i;
         plen_d  = bit_cycles(prescale_i);
         line_d  = 1'b0;
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// Word transmitter: splits a DATA_W-bit word into a high byte
// (zero-extended) and a low byte, sent back to back over one UART.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int DATA_W = 10
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [15:0]       prescale_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              tx_serial_o,
   output logic              busy_o
);

   byte_sel_t   sel_q;
   logic [7:0]  lo_q;
   logic [15:0] pre_q;
   logic [15:0] word_ext;
   logic        lo_pend;
   logic        take;
   logic        ser_ready;
   logic        ser_valid;
   logic        ser_busy;
   logic [7:0]  ser_byte;
   logic [15:0] ser_pre;

   assign word_ext  = 16'(data_i);
   assign lo_pend   = (sel_q == BYTE_LO);
   assign ready_o   = ~ser_busy;
   assign busy_o    = ser_busy;
   assign take      = valid_i & ready_o;

   // High byte comes straight from the input so the start bit
   // leaves one cycle after acceptance.
   assign ser_valid = lo_pend | take;
   assign ser_byte  = lo_pend ? lo_q : word_ext[15:8];
   assign ser_pre   = lo_pend ? pre_q : prescale_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sel_q <= BYTE_HI;
         lo_q  <= '0;
         pre_q <= '0;
      end else if (take) begin
         sel_q <= BYTE_LO;
         lo_q  <= word_ext[7:0];
         pre_q <= prescale_i;
      end else if (lo_pend & ser_ready) begin
         sel_q <= BYTE_HI;
      end
   end

   uart_tx_serializer u_ser (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .prescale_i  (ser_pre),
      .data_i      (ser_byte),
      .valid_i     (ser_valid),
      .ready_o     (ser_ready),
      .tx_serial_o (tx_serial_o),
      .busy_o      (ser_busy)
   );

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx against a bit-list line model.
// Expected line levels are derived from word value and bit period.
module tb_uart_word_tx;

   localparam int DATA_W = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              valid = 1'b0;
   logic [15:0]       pre = 16'd1;
   logic [DATA_W-1:0] data = '0;
   logic              ready;
   logic              line;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   uart_word_tx #(.DATA_W(DATA_W)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .prescale_i  (pre),
      .data_i      (data),
      .valid_i     (valid),
      .ready_o     (ready),
      .tx_serial_o (line),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [DATA_W-1:0] d,
                          input logic [15:0] p);
      int waited = 0;
      while (ready !== 1'b1 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_wait", {31'd0, ready}, 32'd1);
      data  = d;
      pre   = p;
      valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Called just after the accepting edge; checks ncyc cycles.
   task automatic run_frame(input logic [DATA_W-1:0] d, input int p,
                            input int ncyc, input bit hold,
                            input bit mix,
                            output logic [7:0] rx_hi,
                            output logic [7:0] rx_lo);
      int   bits[20];
      logic rxb[20];
      int   bp, total, hi, lo, fb, lim;
      bp    = ((p == 0) ? 1 : p) * 8;
      total = 20 * bp;
      hi    = int'(d) >> 8;
      lo    = int'(d) & 255;
      for (int j = 0; j < 10; j++) begin
         bits[j]      = (j == 0) ? 0 : (j == 9) ? 1 : (hi >> (j - 1)) & 1;
         bits[10 + j] = (j == 0) ? 0 : (j == 9) ? 1 : (lo >> (j - 1)) & 1;
         rxb[j]      = 1'b0;
         rxb[10 + j] = 1'b0;
      end
      if (!hold) valid = 1'b0;
      lim = (ncyc < total) ? ncyc : total;
      for (int k = 0; k < lim; k++) begin
         @(negedge clk);
         fb = k / bp;
         chk("line", {31'd0, line}, 32'(bits[fb]));
         chk("busy", {31'd0, busy}, 32'd1);
         chk("ready", {31'd0, ready}, 32'd0);
         if (k % bp == bp / 2) rxb[fb] = line;
         if (mix) begin
            data = DATA_W'($urandom);
            pre  = 16'd5;
         end
      end
      if (ncyc >= total) begin
         @(negedge clk);
         chk("idle_line", {31'd0, line}, 32'd1);
         chk("idle_busy", {31'd0, busy}, 32'd0);
         chk("idle_ready", {31'd0, ready}, 32'd1);
      end
      for (int j = 0; j < 8; j++) begin
         rx_hi[j] = rxb[1 + j];
         rx_lo[j] = rxb[11 + j];
      end
   endtask

   initial begin
      logic [7:0]        h, l, h2, l2;
      logic [DATA_W-1:0] w;
      int                p;

      valid = 1'b1;
      data  = 10'h155;
      repeat (3) @(negedge clk);
      chk("rst_line", {31'd0, line}, 32'd1);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("rst_valid_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid_line", {31'd0, line}, 32'd1);

      present(10'h2A5, 16'd1);
      run_frame(10'h2A5, 1, 100000, 1'b0, 1'b0, h, l);
      chk("s1_hi", 32'(h), 32'h02);
      chk("s1_lo", 32'(l), 32'hA5);

      present(10'h3FF, 16'd1);
      run_frame(10'h3FF, 1, 100000, 1'b1, 1'b0, h, l);
      data = 10'h001;
      @(posedge clk);
      #1;
      run_frame(10'h001, 1, 100000, 1'b0, 1'b0, h2, l2);
      chk("s2_b0", 32'(h), 32'h03);
      chk("s2_b1", 32'(l), 32'hFF);
      chk("s2_b2", 32'(h2), 32'h00);
      chk("s2_b3", 32'(l2), 32'h01);

      w = DATA_W'($urandom);
      present(w, 16'd2);
      run_frame(w, 2, 100000, 1'b1, 1'b1, h, l);
      valid = 1'b0;
      chk("s3_hi", 32'(h), 32'(int'(w) >> 8));
      chk("s3_lo", 32'(l), 32'(int'(w) & 255));

      present(10'h2A5, 16'd0);
      run_frame(10'h2A5, 0, 100000, 1'b0, 1'b0, h, l);
      chk("s4_hi", 32'(h), 32'h02);
      chk("s4_lo", 32'(l), 32'hA5);

      for (int i = 0; i < 6; i++) begin
         w = DATA_W'($urandom);
         p = int'($urandom_range(0, 3));
         present(w, 16'(p));
         run_frame(w, p, 100000, 1'b0, 1'b0, h, l);
         chk("rnd_hi", 32'(h), 32'(int'(w) >> 8));
         chk("rnd_lo", 32'(l), 32'(int'(w) & 255));
      end

      w = 10'h2C3;
      present(w, 16'd1);
      run_frame(w, 1, 15 * 8 + 4, 1'b0, 1'b0, h, l);
      reset = 1'b1;
      valid = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("s6_line", {31'd0, line}, 32'd1);
      chk("s6_ready", {31'd0, ready}, 32'd1);
      chk("s6_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("s6_quiet", {30'd0, line, busy}, 32'd2);
      end
      w = DATA_W'($urandom);
      present(w, 16'd3);
      run_frame(w, 3, 100000, 1'b0, 1'b0, h, l);
      chk("s6_hi", 32'(h), 32'(int'(w) >> 8));
      chk("s6_lo", 32'(l), 32'(int'(w) & 255));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
